// File: rtl/key_event_decoder_pkg.sv
// Shared state encodings and timing helpers for the key gesture decoder.
package key_event_decoder_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PRESSED   = 3'd1;
   localparam logic [2:0] ST_LONG_HELD = 3'd2;
   localparam logic [2:0] ST_WAIT_2ND  = 3'd3;
   localparam logic [2:0] ST_PRESSED2  = 3'd4;

   function automatic int ms_to_cyc(input int clk_freq, input int ms);
      return clk_freq / 1000 * ms;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_event_decoder_fsm.sv
// One key's gesture FSM: turns press/release strobes into click, double-click and long-press pulses.
module key_event_fsm
   import key_event_decoder_pkg::*;
#(
   parameter int LONG_CYC = 1000,
   parameter int DBL_CYC  = 300,
   parameter int CNT_W    = 10
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic press,
   input  logic release_key,
   output logic click_pulse,
   output logic dbl_pulse,
   output logic long_pulse
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;

   // Key events are tested before timeouts so an event on the deadline cycle wins.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         click_pulse <= 1'b0;
         dbl_pulse   <= 1'b0;
         long_pulse  <= 1'b0;
      end else begin
         click_pulse <= 1'b0;
         dbl_pulse   <= 1'b0;
         long_pulse  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (press) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
               end
            end
            ST_PRESSED: begin
               if (release_key) begin
                  state <= ST_WAIT_2ND;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  state      <= ST_LONG_HELD;
                  cnt        <= '0;
                  long_pulse <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_LONG_HELD: begin
               if (release_key) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end
            end
            ST_WAIT_2ND: begin
               if (press) begin
                  state <= ST_PRESSED2;
                  cnt   <= '0;
               end else if (cnt == DBL_LAST) begin
                  state       <= ST_IDLE;
                  cnt         <= '0;
                  click_pulse <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_PRESSED2: begin
               if (release_key) begin
                  state     <= ST_IDLE;
                  cnt       <= '0;
                  dbl_pulse <= 1'b1;
               end else if (cnt == LONG_LAST) begin
                  state      <= ST_LONG_HELD;
                  cnt        <= '0;
                  long_pulse <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key stream into per-key gesture events (click, double click, long press) and held levels.
module key_event_decoder
   import key_event_decoder_pkg::*;
#(
   parameter int KEY_NUM  = 4,
   parameter int CLK_FREQ = 50_000_000,
   parameter int LONG_MS  = 1000,
   parameter int DBL_MS   = 300
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               key_flag,
   input  logic [KEY_NUM-1:0] key_value,
   output logic [KEY_NUM-1:0] key_held,
   output logic [KEY_NUM-1:0] click_pulse,
   output logic [KEY_NUM-1:0] dbl_pulse,
   output logic [KEY_NUM-1:0] long_pulse
);

   localparam int LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
   localparam int DBL_CYC  = ms_to_cyc(CLK_FREQ, DBL_MS);
   localparam int CNT_W    = $clog2(max_int(LONG_CYC, DBL_CYC) + 1);

   logic [KEY_NUM-1:0] image;
   logic [KEY_NUM-1:0] press;
   logic [KEY_NUM-1:0] release_key;

   // Edges are judged against the image of the previous flag, not the live key level.
   assign press       = {KEY_NUM{key_flag}} & image & ~key_value;
   assign release_key = {KEY_NUM{key_flag}} & ~image & key_value;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         image    <= '1;
         key_held <= '0;
      end else if (key_flag) begin
         image    <= key_value;
         key_held <= ~key_value;
      end
   end

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
      key_event_fsm #(
         .LONG_CYC (LONG_CYC),
         .DBL_CYC  (DBL_CYC),
         .CNT_W    (CNT_W)
      ) u_fsm (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .press       (press[k]),
         .release_key (release_key[k]),
         .click_pulse (click_pulse[k]),
         .dbl_pulse   (dbl_pulse[k]),
         .long_pulse  (long_pulse[k])
      );
   end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomized + directed bench for key_event_decoder, scored against a timestamp-based gesture model.
module tb_key_event_decoder;

   localparam int KEY_NUM  = 4;
   localparam int LONG_CYC = 20;
   localparam int DBL_CYC  = 8;

   localparam int M_IDLE  = 0;
   localparam int M_DOWN1 = 1;
   localparam int M_GAP   = 2;
   localparam int M_DOWN2 = 3;
   localparam int M_LONGH = 4;

   typedef struct packed {
      logic [KEY_NUM-1:0] held;
      logic [KEY_NUM-1:0] click;
      logic [KEY_NUM-1:0] dbl;
      logic [KEY_NUM-1:0] lng;
   } out_t;

   logic               sys_clk = 1'b0;
   logic               sys_rst_n = 1'b0;
   logic               key_flag = 1'b0;
   logic [KEY_NUM-1:0] key_value = '1;
   logic [KEY_NUM-1:0] key_held;
   logic [KEY_NUM-1:0] click_pulse;
   logic [KEY_NUM-1:0] dbl_pulse;
   logic [KEY_NUM-1:0] long_pulse;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   out_t exp_q[$];
   int click_tot[KEY_NUM];
   int dbl_tot[KEY_NUM];
   int long_tot[KEY_NUM];

   key_event_decoder #(
      .KEY_NUM  (KEY_NUM),
      .CLK_FREQ (1000),
      .LONG_MS  (20),
      .DBL_MS   (8)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_flag    (key_flag),
      .key_value   (key_value),
      .key_held    (key_held),
      .click_pulse (click_pulse),
      .dbl_pulse   (dbl_pulse),
      .long_pulse  (long_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: each key remembers its gesture phase and the edge index where that phase began.
   int                 mode[KEY_NUM];
   int                 t_mark[KEY_NUM];
   logic [KEY_NUM-1:0] img = '1;

   always @(posedge sys_clk) begin
      out_t e;
      e = '0;
      if (!sys_rst_n) begin
         img = '1;
         for (int k = 0; k < KEY_NUM; k++) begin
            mode[k]   = M_IDLE;
            t_mark[k] = 0;
         end
      end else begin
         for (int k = 0; k < KEY_NUM; k++) begin
            bit pr, rl;
            int el;
            pr = key_flag && img[k] && !key_value[k];
            rl = key_flag && !img[k] && key_value[k];
            el = cyc - t_mark[k];
            case (mode[k])
               M_IDLE:  if (pr) begin mode[k] = M_DOWN1; t_mark[k] = cyc; end
               M_DOWN1: if (rl) begin mode[k] = M_GAP; t_mark[k] = cyc; end
                        else if (el == LONG_CYC) begin e.lng[k] = 1'b1; mode[k] = M_LONGH; end
               M_GAP:   if (pr) begin mode[k] = M_DOWN2; t_mark[k] = cyc; end
                        else if (el == DBL_CYC) begin e.click[k] = 1'b1; mode[k] = M_IDLE; end
               M_DOWN2: if (rl) begin e.dbl[k] = 1'b1; mode[k] = M_IDLE; end
                        else if (el == LONG_CYC) begin e.lng[k] = 1'b1; mode[k] = M_LONGH; end
               default: if (rl) mode[k] = M_IDLE;
            endcase
         end
         if (key_flag) img = key_value;
         e.held = ~img;
      end
      exp_q.push_back(e);
      cyc++;
   end

   // Monitor: pops one expectation per cycle and compares everything the DUT presents.
   always @(negedge sys_clk) begin
      out_t e, got;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!sys_rst_n) e = '0;
         got = {key_held, click_pulse, dbl_pulse, long_pulse};
         total++;
         if (got !== e) begin
            bad++;
            $display("[TB] FAIL outputs cyc=%0d: got held=%b click=%b dbl=%b long=%b, want held=%b click=%b dbl=%b long=%b",
                     cyc, got.held, got.click, got.dbl, got.lng, e.held, e.click, e.dbl, e.lng);
         end
         for (int k = 0; k < KEY_NUM; k++) begin
            if (click_pulse[k] === 1'b1) click_tot[k]++;
            if (dbl_pulse[k] === 1'b1) dbl_tot[k]++;
            if (long_pulse[k] === 1'b1) long_tot[k]++;
         end
      end
   end

   task automatic step(input logic flag, input logic [KEY_NUM-1:0] v);
      key_flag  = flag;
      key_value = v;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, key_value);
   endtask

   task automatic apply_stimulus(input logic [KEY_NUM-1:0] v);
      step(1'b1, v);
   endtask

   task automatic check_output(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   int c0[KEY_NUM], d0[KEY_NUM], l0[KEY_NUM];

   task automatic snap();
      for (int k = 0; k < KEY_NUM; k++) begin
         c0[k] = click_tot[k];
         d0[k] = dbl_tot[k];
         l0[k] = long_tot[k];
      end
   endtask

   initial begin
      logic [KEY_NUM-1:0] nv;
      for (int k = 0; k < KEY_NUM; k++) begin
         click_tot[k] = 0;
         dbl_tot[k]   = 0;
         long_tot[k]  = 0;
      end
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      idle(2);

      $display("[TB] single click on key0");
      snap();
      apply_stimulus(4'b1110);
      idle(4);
      apply_stimulus(4'b1111);
      idle(12);
      check_output("t1 click0", click_tot[0] - c0[0], 1);
      check_output("t1 dbl0", dbl_tot[0] - d0[0], 0);
      check_output("t1 long0", long_tot[0] - l0[0], 0);

      $display("[TB] double click on key1");
      snap();
      apply_stimulus(4'b1101);
      idle(2);
      apply_stimulus(4'b1111);
      idle(3);
      apply_stimulus(4'b1101);
      idle(2);
      apply_stimulus(4'b1111);
      idle(12);
      check_output("t2 dbl1", dbl_tot[1] - d0[1], 1);
      check_output("t2 click1", click_tot[1] - c0[1], 0);

      $display("[TB] long press on key2");
      snap();
      apply_stimulus(4'b1011);
      idle(29);
      apply_stimulus(4'b1111);
      idle(12);
      check_output("t3 long2", long_tot[2] - l0[2], 1);
      check_output("t3 click2", click_tot[2] - c0[2], 0);

      $display("[TB] key3 release on the long deadline");
      snap();
      apply_stimulus(4'b0111);
      idle(19);
      apply_stimulus(4'b1111);
      idle(12);
      check_output("t4 click3", click_tot[3] - c0[3], 1);
      check_output("t4 long3", long_tot[3] - l0[3], 0);

      $display("[TB] keys 0 and 2 together");
      snap();
      apply_stimulus(4'b1010);
      idle(2);
      apply_stimulus(4'b1010);
      idle(1);
      apply_stimulus(4'b1111);
      idle(12);
      check_output("t5 click0", click_tot[0] - c0[0], 1);
      check_output("t5 click2", click_tot[2] - c0[2], 1);
      check_output("t5 dbl0", dbl_tot[0] - d0[0], 0);

      $display("[TB] reset during double-click gap");
      snap();
      apply_stimulus(4'b1110);
      idle(2);
      apply_stimulus(4'b1111);
      idle(3);
      sys_rst_n = 1'b0;
      idle(2);
      sys_rst_n = 1'b1;
      idle(14);
      check_output("t6 click0", click_tot[0] - c0[0], 0);

      $display("[TB] random key traffic");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(5) == 0) begin
            nv = key_value;
            for (int k = 0; k < KEY_NUM; k++)
               if ($urandom_range(2) == 0) nv[k] = ~nv[k];
            apply_stimulus(nv);
         end else begin
            idle(1);
         end
      end
      apply_stimulus(4'b1111);
      idle(30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
